// File: rtl/divider_pipe_ctrl.sv
// divider_pipe_ctrl: multi-cycle radix-2^STEPS restoring divider, signed/unsigned per op,
// with divide-by-zero and signed-overflow short cuts and valid/ready handshakes.
module divider_pipe_ctrl #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_by_zero,
  output logic             out_overflow
);
  localparam int ITERS = WIDTH / STEPS;
  localparam int CW = $clog2(ITERS + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q, quo_d, dvs_q, dvd_mag, dvs_mag;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             neg_q_q, neg_r_q, ovf;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dvd_mag = (in_signed && in_dividend[WIDTH-1]) ? -in_dividend : in_dividend;
  assign dvs_mag = (in_signed && in_divisor[WIDTH-1]) ? -in_divisor : in_divisor;
  assign ovf = in_signed && (in_dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&in_divisor);
  // quo_q starts as the dividend magnitude; its MSBs feed the remainder as quotient bits enter at the LSB
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    for (int i = 0; i < STEPS; i++) begin
      rem_d = {rem_d[WIDTH-1:0], quo_d[WIDTH-1]};
      quo_d = {quo_d[WIDTH-2:0], rem_d >= {1'b0, dvs_q}};
      rem_d = quo_d[0] ? rem_d - {1'b0, dvs_q} : rem_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      out_quotient    <= '0;
      out_remainder   <= '0;
      out_div_by_zero <= 1'b0;
      out_overflow    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          if (in_divisor == '0) begin
            state_q         <= DONE;
            out_quotient    <= '1;
            out_remainder   <= in_dividend;
            out_div_by_zero <= 1'b1;
            out_overflow    <= 1'b0;
          end else if (ovf) begin
            state_q         <= DONE;
            out_quotient    <= in_dividend;
            out_remainder   <= '0;
            out_div_by_zero <= 1'b0;
            out_overflow    <= 1'b1;
          end else begin
            state_q <= CALC;
            quo_q   <= dvd_mag;
            dvs_q   <= dvs_mag;
            rem_q   <= '0;
            cnt_q   <= '0;
            neg_q_q <= in_signed && (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
            neg_r_q <= in_signed && in_dividend[WIDTH-1];
          end
        end
        CALC: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          cnt_q   <= cnt_q + 1'b1;
          state_q <= (cnt_q == CW'(ITERS - 1)) ? FIX : CALC;
        end
        FIX: begin
          state_q         <= DONE;
          out_quotient    <= neg_q_q ? -quo_q : quo_q;
          out_remainder   <= neg_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          out_div_by_zero <= 1'b0;
          out_overflow    <= 1'b0;
        end
        DONE: state_q <= out_ready ? IDLE : DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
